// File: rtl/reg_line_window_if.sv
// rtl/reg_line_window_if.sv - line-in / window-out handshake bundle for reg_line_window
interface reg_line_window_if #(
    parameter int SAMPLE_W    = 8,
    parameter int N_SAMPLES   = 9,
    parameter int TAPS        = 8,
    parameter int BLOCK_LINES = 15
) ();
    localparam int LW    = N_SAMPLES * SAMPLE_W;
    localparam int IDX_W = ($clog2(BLOCK_LINES - TAPS + 1) > 1) ? $clog2(BLOCK_LINES - TAPS + 1) : 1;

    logic                 IN_VALID;
    logic                 IN_READY;
    logic [LW-1:0]        DATA_IN;
    logic                 OUT_VALID;
    logic                 OUT_READY;
    logic [TAPS*LW-1:0]   WINDOW_OUT;
    logic [IDX_W-1:0]     WIN_IDX;
    logic                 BLOCK_LAST;

    modport master (
        output IN_VALID, DATA_IN, OUT_READY,
        input  IN_READY, OUT_VALID, WINDOW_OUT, WIN_IDX, BLOCK_LAST
    );

    modport slave (
        input  IN_VALID, DATA_IN, OUT_READY,
        output IN_READY, OUT_VALID, WINDOW_OUT, WIN_IDX, BLOCK_LAST
    );
endinterface

// File: rtl/reg_line_window.sv
// rtl/reg_line_window.sv - TAPS-line vertical filter window with block-aligned tagging
module reg_line_window #(
    parameter int SAMPLE_W    = 8,
    parameter int N_SAMPLES   = 9,
    parameter int TAPS        = 8,
    parameter int BLOCK_LINES = 15
) (
    input  logic             CLK,
    input  logic             RST_SYNC,
    input  logic             CLEAR,
    reg_line_window_if.slave bus
);
    localparam int LW     = N_SAMPLES * SAMPLE_W;
    localparam int WW     = TAPS * LW;
    localparam int IDX_W  = ($clog2(BLOCK_LINES - TAPS + 1) > 1) ? $clog2(BLOCK_LINES - TAPS + 1) : 1;
    localparam int BCNT_W = (BLOCK_LINES > 1) ? $clog2(BLOCK_LINES) : 1;
    localparam int FCNT_W = $clog2(TAPS + 1);

    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLOCK_LINES - 1);
    localparam logic [BCNT_W-1:0] TAPS_M1   = BCNT_W'(TAPS - 1);
    localparam logic [FCNT_W-1:0] FCNT_FULL = FCNT_W'(TAPS);
    localparam logic [FCNT_W-1:0] FCNT_FIRE = FCNT_W'(TAPS - 1);

    logic [WW-1:0]     win_q;
    logic [FCNT_W-1:0] fcnt_q;
    logic [BCNT_W-1:0] bcnt_q;
    logic              pend_q;
    logic [IDX_W-1:0]  idx_q;
    logic              last_q;

    logic              in_ready;
    logic              accept;
    logic              block_end;
    logic              fire;
    logic [BCNT_W-1:0] idx_full;

    // A held window blocks the shift unless it is being consumed this same cycle.
    always_comb begin
        in_ready  = !CLEAR && (!pend_q || bus.OUT_READY);
        accept    = bus.IN_VALID && in_ready;
        block_end = (bcnt_q == BCNT_LAST);
        fire      = accept && (fcnt_q >= FCNT_FIRE);
        idx_full  = bcnt_q - TAPS_M1;
    end

    always_ff @(posedge CLK) begin
        if (RST_SYNC || CLEAR) begin
            win_q  <= '0;
            fcnt_q <= '0;
            bcnt_q <= '0;
            pend_q <= 1'b0;
            idx_q  <= '0;
            last_q <= 1'b0;
        end else begin
            if (accept) begin
                win_q  <= {bus.DATA_IN, win_q[WW-1:LW]};
                bcnt_q <= block_end ? '0 : bcnt_q + 1'b1;
                if (block_end)
                    fcnt_q <= '0;
                else if (fcnt_q != FCNT_FULL)
                    fcnt_q <= fcnt_q + 1'b1;
            end
            // Tags are captured only when a window fires so they stay frozen under backpressure.
            if (fire) begin
                pend_q <= 1'b1;
                idx_q  <= idx_full[IDX_W-1:0];
                last_q <= block_end;
            end else if (pend_q && bus.OUT_READY) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign bus.IN_READY   = in_ready;
    assign bus.OUT_VALID  = pend_q;
    assign bus.WINDOW_OUT = win_q;
    assign bus.WIN_IDX    = idx_q;
    assign bus.BLOCK_LAST = last_q;
endmodule

// File: tb/tb_reg_line_window.sv
// tb/tb_reg_line_window.sv - scoreboard bench for reg_line_window
module tb_reg_line_window;
    localparam int SAMPLE_W    = 8;
    localparam int N_SAMPLES   = 9;
    localparam int TAPS        = 8;
    localparam int BLOCK_LINES = 15;
    localparam int LW          = SAMPLE_W * N_SAMPLES;
    localparam int WW          = TAPS * LW;
    localparam int IDX_W       = ($clog2(BLOCK_LINES - TAPS + 1) > 1) ? $clog2(BLOCK_LINES - TAPS + 1) : 1;

    typedef struct {
        logic [WW-1:0]    win;
        logic [IDX_W-1:0] idx;
        logic             last;
    } exp_t;

    logic CLK = 1'b0;
    logic RST_SYNC;
    logic CLEAR;

    reg_line_window_if #(
        .SAMPLE_W(SAMPLE_W), .N_SAMPLES(N_SAMPLES), .TAPS(TAPS), .BLOCK_LINES(BLOCK_LINES)
    ) bus ();

    reg_line_window #(
        .SAMPLE_W(SAMPLE_W), .N_SAMPLES(N_SAMPLES), .TAPS(TAPS), .BLOCK_LINES(BLOCK_LINES)
    ) dut (
        .CLK(CLK),
        .RST_SYNC(RST_SYNC),
        .CLEAR(CLEAR),
        .bus(bus.slave)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [LW-1:0] blk[$];
    exp_t          exp_q[$];

    task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] pat(input int v);
        logic [LW-1:0] l;
        for (int j = 0; j < N_SAMPLES; j++) l[j*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(v);
        return l;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int j = 0; j < N_SAMPLES; j++) l[j*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'($urandom);
        return l;
    endfunction

    function automatic logic [LW-1:0] slice(input logic [WW-1:0] w, input int k);
        return w[k*LW +: LW];
    endfunction

    // Reference model: a block is just the list of lines received since its start;
    // every line from the TAPS-th on yields a window of the TAPS newest ones.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #1;
            if (RST_SYNC || CLEAR) begin
                blk.delete();
                exp_q.delete();
            end else if (bus.IN_VALID && bus.IN_READY) begin
                blk.push_back(bus.DATA_IN);
                if (blk.size() >= TAPS) begin
                    for (int k = 0; k < TAPS; k++)
                        e.win[k*LW +: LW] = blk[blk.size() - TAPS + k];
                    e.idx  = IDX_W'(blk.size() - TAPS);
                    e.last = (blk.size() == BLOCK_LINES);
                    exp_q.push_back(e);
                end
                if (blk.size() == BLOCK_LINES) blk.delete();
            end
        end
    end

    // Monitor: compares handshake and every presented window against the scoreboard.
    initial begin
        logic exp_ready;
        forever begin
            @(negedge CLK);
            exp_ready = !CLEAR && (exp_q.size() == 0 || bus.OUT_READY);
            chk("in_ready", WW'(bus.IN_READY), WW'(exp_ready));
            chk("out_valid", WW'(bus.OUT_VALID), WW'(exp_q.size() != 0));
            if (bus.OUT_VALID && exp_q.size() != 0) begin
                chk("window", bus.WINDOW_OUT, exp_q[0].win);
                chk("win_idx", WW'(bus.WIN_IDX), WW'(exp_q[0].idx));
                chk("block_last", WW'(bus.BLOCK_LAST), WW'(exp_q[0].last));
                if (bus.OUT_READY) void'(exp_q.pop_front());
            end
        end
    end

    task automatic push(input logic [LW-1:0] d);
        int t;
        bus.IN_VALID = 1'b1;
        bus.DATA_IN  = d;
        t = 0;
        @(negedge CLK);
        while (!bus.IN_READY && t < 200) begin
            @(negedge CLK);
            t++;
        end
        if (!bus.IN_READY) chk("push_timeout", WW'(bus.IN_READY), WW'(1));
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
    endtask

    initial begin
        logic [WW-1:0] saved;
        RST_SYNC      = 1'b1;
        CLEAR         = 1'b0;
        bus.IN_VALID  = 1'b1;
        bus.DATA_IN   = pat(8'hAA);
        bus.OUT_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_SYNC     = 1'b0;
        bus.IN_VALID = 1'b0;
        chk("rst_out_valid", WW'(bus.OUT_VALID), '0);
        chk("rst_in_ready", WW'(bus.IN_READY), WW'(1));
        chk("rst_window", bus.WINDOW_OUT, '0);
        chk("rst_win_idx", WW'(bus.WIN_IDX), '0);
        chk("rst_block_last", WW'(bus.BLOCK_LAST), '0);

        // Fill with backpressure held so the first window stays pending.
        for (int i = 1; i <= TAPS; i++) push(pat(i));
        chk("fill_valid", WW'(bus.OUT_VALID), WW'(1));
        chk("fill_slice0", WW'(slice(bus.WINDOW_OUT, 0)), WW'(pat(1)));
        chk("fill_slice7", WW'(slice(bus.WINDOW_OUT, TAPS - 1)), WW'(pat(8)));
        chk("fill_idx", WW'(bus.WIN_IDX), '0);

        saved        = bus.WINDOW_OUT;
        bus.IN_VALID = 1'b1;
        bus.DATA_IN  = pat(9);
        repeat (5) begin
            @(negedge CLK);
            chk("bp_in_ready", WW'(bus.IN_READY), '0);
            chk("bp_stable", bus.WINDOW_OUT, saved);
        end
        @(posedge CLK);
        #1;
        bus.OUT_READY = 1'b1;
        @(negedge CLK);
        chk("bp_release_ready", WW'(bus.IN_READY), WW'(1));
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        chk("l9_valid", WW'(bus.OUT_VALID), WW'(1));
        chk("l9_idx", WW'(bus.WIN_IDX), WW'(1));
        chk("l9_slice0", WW'(slice(bus.WINDOW_OUT, 0)), WW'(pat(2)));
        chk("l9_slice7", WW'(slice(bus.WINDOW_OUT, TAPS - 1)), WW'(pat(9)));

        // Finish the block and start the next one.
        for (int i = 10; i <= 23; i++) push(pat(i));
        chk("wrap_valid", WW'(bus.OUT_VALID), WW'(1));
        chk("wrap_idx", WW'(bus.WIN_IDX), '0);
        chk("wrap_slice0", WW'(slice(bus.WINDOW_OUT, 0)), WW'(pat(16)));
        chk("wrap_last", WW'(bus.BLOCK_LAST), '0);

        // Randomised traffic with occasional flushes.
        for (int c = 0; c < 2000; c++) begin
            @(posedge CLK);
            #1;
            bus.IN_VALID  = ($urandom_range(0, 3) != 0);
            bus.DATA_IN   = rand_line();
            bus.OUT_READY = $urandom_range(0, 1) != 0;
            CLEAR         = ($urandom_range(0, 79) == 0);
        end
        @(posedge CLK);
        #1;
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b0;
        CLEAR         = 1'b1;
        @(posedge CLK);
        #1;
        CLEAR = 1'b0;

        // CLEAR mid-fill.
        for (int i = 0; i < 5; i++) push(pat(8'h31 + i));
        CLEAR        = 1'b1;
        bus.IN_VALID = 1'b1;
        bus.DATA_IN  = pat(8'hEE);
        @(negedge CLK);
        chk("clr_in_ready", WW'(bus.IN_READY), '0);
        @(posedge CLK);
        #1;
        CLEAR        = 1'b0;
        bus.IN_VALID = 1'b0;
        for (int i = 0; i < TAPS - 1; i++) push(pat(8'h40 + i));
        chk("clr_no_window", WW'(bus.OUT_VALID), '0);
        push(pat(8'h47));
        chk("clr_valid", WW'(bus.OUT_VALID), WW'(1));
        chk("clr_idx", WW'(bus.WIN_IDX), '0);
        chk("clr_slice0", WW'(slice(bus.WINDOW_OUT, 0)), WW'(pat(8'h40)));

        // Reset with a window pending.
        RST_SYNC = 1'b1;
        @(posedge CLK);
        #1;
        RST_SYNC = 1'b0;
        chk("rst2_valid", WW'(bus.OUT_VALID), '0);
        chk("rst2_window", bus.WINDOW_OUT, '0);
        bus.OUT_READY = 1'b1;
        for (int i = 1; i <= TAPS; i++) push(pat(i));
        chk("rst2_fill_valid", WW'(bus.OUT_VALID), WW'(1));
        chk("rst2_fill_slice0", WW'(slice(bus.WINDOW_OUT, 0)), WW'(pat(1)));

        repeat (4) @(posedge CLK);
        #1;
        chk("drain", WW'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end
endmodule
